addsub_seq: RTL

Multi-precision add/subtract sequencer. It accepts NIBBLES×4-bit operands over a valid/ready request channel and computes the result serially, one nibble per clock, through a single shared 4-bit add/sub slice. A registered carry links the nibbles, and the result is returned on a valid/ready response channel. The block sits in front of the 4-bit adder-subtractor datapath, so wide arithmetic runs on one narrow slice at the cost of latency.

---
 rtl/addsub_seq_pkg.sv | 15 +
 rtl/addsub_seq_nibble_addsub.sv | 28 ++
 rtl/addsub_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/addsub_seq_pkg.sv
// Shared constants and types for the serial multi-precision add/sub sequencer.
package addsub_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_seq_nibble_addsub.sv
// Combinational 4-bit add/sub slice; inverts B for subtract, carry-in supplied externally.
module nibble_addsub
    import addsub_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W-1:0] bb;
    logic [NIBBLE_W:0]   full;
    logic [NIBBLE_W-1:0] low;

    always_comb begin
        bb   = (sub == OP_SUB) ? ~b : b;
        // Sum of the low three bits exposes the carry into the MSB for overflow detection.
        low  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, bb[NIBBLE_W-2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};
        full = {1'b0, a} + {1'b0, bb} + {{NIBBLE_W{1'b0}}, cin};
        s    = full[NIBBLE_W-1:0];
        cout = full[NIBBLE_W];
        c3   = low[NIBBLE_W-1];
    end

endmodule

// File: rtl/addsub_seq.sv
// Serial multi-precision add/subtract sequencer, one nibble per clock.
// Optional rsp_zero output enabled by defining ADDSUB_SEQ_ZERO_FLAG_EN.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
    input  logic                    req_sub,
    input  logic                    req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_sum,
    output logic                    rsp_cout,
    output logic                    rsp_ovf
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
    ,output logic                   rsp_zero
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t              state, state_nx;
    logic [W-1:0]        a_r, b_r;
    logic [W-NIBBLE_W-1:0] acc;
    logic                sub_r, carry;
    logic [IDX_W-1:0]    idx;
    logic [NIBBLE_W-1:0] s;
    logic                cout, c3;
    logic                accept, last;
    logic [W-1:0]        result;

    nibble_addsub u_slice (
        .a    (a_r[NIBBLE_W-1:0]),
        .b    (b_r[NIBBLE_W-1:0]),
        .cin  (carry),
        .sub  (sub_r),
        .s    (s),
        .cout (cout),
        .c3   (c3)
    );

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign last   = (state == RUN) && (idx == IDX_W'(NIBBLES - 1));
    // Result assembled by shifting nibbles in from the top; after the last one it is in order.
    assign result = {s, acc};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            sub_r     <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
            rsp_zero  <= 1'b0;
`endif
        end else begin
            req_ready <= (state_nx == IDLE);
            rsp_valid <= (state_nx == DONE);
            if (accept) begin
                a_r   <= req_a;
                b_r   <= req_b;
                sub_r <= req_sub;
                carry <= (req_sub == OP_SUB) ? ~req_cin : req_cin;
                idx   <= '0;
            end
            // Operands shift down so the slice always sees the current nibble at bit 0.
            if (state == RUN) begin
                a_r   <= a_r >> NIBBLE_W;
                b_r   <= b_r >> NIBBLE_W;
                acc   <= result[W-1:NIBBLE_W];
                carry <= cout;
                idx   <= idx + IDX_W'(1);
                if (last) begin
                    idx      <= '0;
                    rsp_sum  <= result;
                    rsp_cout <= cout;
                    rsp_ovf  <= c3 ^ cout;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
                    rsp_zero <= (result == '0);
`endif
                end
            end
        end
    end

endmodule
